digit_split_arbiter: RTL

//  Shares one iterative tens/units splitter among NREQ requesters, such as score

---
 rtl/digit_split_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/digit_split_arbiter.sv
// Round-robin arbiter sharing one repeated-subtract-10 tens/units splitter among
// NREQ requesters; returns saturated 0..99 digits with strobe, ack and served id.
module digit_split_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] value_flat,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic              out_valid,
    output logic [IDW-1:0]    out_id,
    output logic [3:0]        tens,
    output logic [3:0]        units,
    output logic              ovf
);

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    localparam logic [W-1:0] TEN = W'(10);
    localparam logic [W-1:0] MAX = W'(99);

    state_t          state;
    logic [IDW-1:0]  last_id;
    logic [IDW-1:0]  id;
    logic [W-1:0]    rem;
    logic [3:0]      tcnt;
    logic            sat;

    logic            any_req;
    logic [IDW-1:0]  grant_id;
    logic [W-1:0]    grant_val;
    logic [IDW:0]    start;
    logic [NREQ-1:0] req_rot;
    logic            sub_done;

    // Rotate req so bit 0 is the requester just after last_id, then take the first set bit.
    always_comb begin
        int off;
        int g;
        any_req   = 1'b0;
        off       = 0;
        grant_val = '0;
        start     = {1'b0, last_id} + (IDW+1)'(1);
        req_rot   = NREQ'({req, req} >> start);
        for (int k = 0; k < NREQ; k++) begin
            if (!any_req && req_rot[k]) begin
                any_req = 1'b1;
                off     = k;
            end
        end
        g        = (int'(last_id) + 1 + off) % NREQ;
        grant_id = IDW'(g);
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) grant_val = value_flat[i*W +: W];
        end
    end

    assign sub_done  = sat || (rem < TEN);
    assign out_valid = (state == DONE);
    assign ack       = out_valid ? (NREQ'(1) << id) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            last_id <= IDW'(NREQ - 1);
            out_id  <= '0;
            tens    <= '0;
            units   <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= SUB;
                        busy  <= 1'b1;
                    end
                end
                SUB: begin
                    if (sub_done) begin
                        state  <= DONE;
                        out_id <= id;
                        tens   <= sat ? 4'd9 : tcnt;
                        units  <= sat ? 4'd9 : rem[3:0];
                        ovf    <= sat;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    last_id <= id;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Conversion datapath: loaded at grant, needs no reset since it is only read in SUB/DONE.
    always_ff @(posedge clk) begin
        if (state == IDLE && any_req) begin
            rem  <= grant_val;
            tcnt <= '0;
            id   <= grant_id;
            sat  <= (grant_val > MAX);
        end else if (state == SUB && !sub_done) begin
            rem  <= rem - TEN;
            tcnt <= tcnt + 4'd1;
        end
    end

endmodule
